imem_responder: RTL and testbench
=================================

# imem_responder

Instruction-memory responder serving the fetch side of the core. Accepts a fetch request (byte-address PC) over a valid/ready handshake. Reads a word-addressed instruction store and returns the 32-bit instruction word after a fixed, parameterised access latency. Supports pipeline-redirect flushes and a program-load write port, and flags misaligned or out-of-range fetches.

## Interface
- ADDR_W, 10: word-address width; store depth = 2^ADDR_W words.
- LATENCY, 2: cycles from request acceptance to rsp_valid. Legal range 1..15.
- NOP_WORD, 32'h0000_0000: word returned on an errored fetch and as the reset value of rsp_instr.

- clk  in  1  main clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; sampled on posedge clk.
- req_valid  in  1  fetch request present.
- req_addr  in  32  byte address (PC) of the requested instruction.
- req_ready  out  1  responder can accept a request this cycle.
- rsp_valid  out  1  response word valid.
- rsp_instr  out  32  fetched instruction (prefetch word).
- rsp_addr  out  32  byte address the response belongs to.
- rsp_err  out  1  response is for a misaligned or out-of-range address.
- rsp_ready  in  1  consumer accepts the response this cycle.
- flush  in  1  redirect: drop any in-flight or held response.
- prog_we  in  1  program-load write enable.
- prog_addr  in  ADDR_W  program-load word index.
- prog_data  in  32  program-load data.

## Operation
- States: IDLE, BUSY, HOLD.
- Accept: a request is accepted when req_valid && req_ready.
- req_ready = !reset && !flush && (state==IDLE || (state==HOLD && rsp_ready)).
- Word index = req_addr[ADDR_W+1:2].
- Error when req_addr[1:0]!=0 or req_addr[31:ADDR_W+2]!=0. The errored response carries rsp_instr=NOP_WORD and rsp_err=1.
- On accept, the responder captures the store read, address and error into internal registers. Later writes never alter an in-flight response.
- Accept with LATENCY==1: go to HOLD.
- Accept with LATENCY>1: go to BUSY with down-counter = LATENCY-1. BUSY decrements each cycle and goes to HOLD when the counter reaches 1 (rsp_valid rises that edge).
- HOLD: rsp_valid=1 with rsp_instr/rsp_addr/rsp_err stable until rsp_ready.
- On rsp_ready with no new accept: go to IDLE.
- On rsp_ready with a same-cycle accept (back-to-back): reload as on accept from IDLE.
- flush (any state): next state IDLE, rsp_valid=0 next cycle. A same-cycle request is not accepted; the held or in-flight response is discarded.
- Program load: prog_we writes prog_data to store[prog_addr] at posedge, in any state.
- A write and an accept to the same word in the same cycle return the OLD word.
- The store is not cleared by reset.
- Counter width is 4 bits. There is no wrap: the counter reloads only on accept.

## Timing
- Reset (takes priority over flush):
  - state=IDLE; rsp_valid=0; rsp_instr=NOP_WORD; rsp_addr=0; rsp_err=0; counter=0.
  - req_ready=0 while reset is high and 1 in the first cycle after.
  - Reset mid-BUSY or mid-HOLD drops the response.
  - prog_we is still honoured during reset.
- Latency: accept at posedge N gives rsp_valid high after posedge N+LATENCY-1, i.e. LATENCY cycles after the accepting cycle's edge. With LATENCY=1 the word is visible the cycle after accept.
- Throughput:
  - LATENCY=1 with rsp_ready held high gives one response per cycle.
  - Otherwise the responder sustains one response per LATENCY cycles; there is no request pipelining beyond depth 1.
- While rsp_valid=1 && rsp_ready=0, all rsp_* outputs hold unchanged (no response loss under backpressure).
- Outputs are registered; req_ready is the only combinational output.

## Test plan
- Basic fetch:
  - Stimulus: LATENCY=2; preload store[3]=32'hC000_0008 via prog port; request 0x0C.
  - Response: rsp_valid exactly 2 cycles after accept; rsp_instr=32'hC000_0008, rsp_addr=0x0C, rsp_err=0.
- Backpressure and back-to-back:
  - Stimulus: hold rsp_ready=0 for 5 cycles, then assert it alongside a new request 0x10.
  - Response: outputs stable for all 5 cycles; the new request is accepted on the handshake cycle; the next response arrives 2 cycles later with store[4].
- Errors:
  - Stimulus: request 0x0000_0006, then request 0x0001_0000 (ADDR_W=10).
  - Response: both return rsp_err=1 and rsp_instr=NOP_WORD.
- Flush:
  - Stimulus: assert flush in BUSY, then assert flush with req_valid in HOLD.
  - Response: rsp_valid=0 the next cycle; the same-cycle request is not accepted (req_ready=0); a request in the following cycle completes normally.
- Write/read race:
  - Stimulus: store[7]=A; same cycle, accept 0x1C and prog_we to index 7 with B.
  - Response: rsp_instr=A; a subsequent fetch of 0x1C returns B.
- Reset mid-operation:
  - Stimulus: assert reset in HOLD.
  - Response: the next cycle shows rsp_valid=0, rsp_instr=NOP_WORD, rsp_addr=0; req_ready=1 the cycle after reset drops; store contents are preserved.

Source files
------------

// File: rtl/imem_responder.sv
// Instruction-memory responder: single-outstanding fetch with fixed access latency,
// redirect flush, and a program-load write port into the word-addressed store.
module imem_responder #(
    parameter int          ADDR_W   = 10,
    parameter int          LATENCY  = 2,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [31:0]       req_addr,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [31:0]       rsp_instr,
    output logic [31:0]       rsp_addr,
    output logic              rsp_err,
    input  logic              rsp_ready,
    input  logic              flush,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [31:0]       prog_data
);

    typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       instr_q, instr_d;
    logic [31:0]       addr_q, addr_d;
    logic              err_q, err_d;
    logic [31:0]       mem_q [0:(1<<ADDR_W)-1];

    logic              accept;
    logic              req_err;
    logic [ADDR_W-1:0] req_idx;

    assign req_idx   = req_addr[ADDR_W+1:2];
    assign req_err   = (req_addr[1:0] != 2'b00) || (req_addr[31:ADDR_W+2] != '0);
    assign req_ready = !reset && !flush &&
                       ((state_q == IDLE) || ((state_q == HOLD) && rsp_ready));
    assign accept    = req_valid && req_ready;

    // Store is deliberately not reset; a same-edge write is seen only by later reads.
    always_ff @(posedge clk) begin
        if (prog_we) begin
            mem_q[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            rsp_valid_q <= 1'b0;
            instr_q     <= NOP_WORD;
            addr_q      <= 32'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            instr_q     <= instr_d;
            addr_q      <= addr_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush) begin
            state_d = IDLE;
        end else if (accept) begin
            state_d = (LATENCY == 1) ? HOLD : BUSY;
            cnt_d   = 4'(LATENCY - 1);
        end else begin
            case (state_q)
                BUSY: begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (rsp_ready) begin
                        state_d = IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Response payload is captured at accept so later program writes cannot disturb it.
    always_comb begin
        instr_d     = instr_q;
        addr_d      = addr_q;
        err_d       = err_q;
        rsp_valid_d = (state_d == HOLD);
        if (accept) begin
            instr_d = req_err ? NOP_WORD : mem_q[req_idx];
            addr_d  = req_addr;
            err_d   = req_err;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_instr = instr_q;
    assign rsp_addr  = addr_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: directed scenarios with literal expectations, then random
// traffic compared each cycle against a transaction-level model of the fetch port.
module tb_imem_responder;

    localparam int          ADDR_W = 10;
    localparam int          LAT    = 2;
    localparam logic [31:0] NOP    = 32'h0000_0000;
    localparam logic [31:0] WORD_A = 32'hAAAA_0001;
    localparam logic [31:0] WORD_B = 32'hBBBB_0002;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic [31:0]       req_addr;
    logic              req_ready;
    logic              rsp_valid;
    logic [31:0]       rsp_instr;
    logic [31:0]       rsp_addr;
    logic              rsp_err;
    logic              rsp_ready;
    logic              flush;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [31:0]       prog_data;

    imem_responder #(.ADDR_W(ADDR_W), .LATENCY(LAT), .NOP_WORD(NOP)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_instr(rsp_instr), .rsp_addr(rsp_addr),
        .rsp_err(rsp_err), .rsp_ready(rsp_ready), .flush(flush),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Model: at most one outstanding fetch, visible from a known edge onwards.
    logic [31:0] m_mem [0:(1<<ADDR_W)-1];
    bit          m_have = 0;
    int          m_vis_edge = 0;
    logic [31:0] m_instr, m_addr;
    bit          m_err;
    bit          m_rst = 0;
    int          edge_n = 0;

    function automatic bit m_vis();
        return m_have && (edge_n >= m_vis_edge);
    endfunction

    function automatic bit m_ready();
        return !reset && !flush && (!m_have || (m_vis() && rsp_ready));
    endfunction

    always @(posedge clk) begin
        bit acc, vis;
        acc = req_valid && m_ready();
        vis = m_vis();
        edge_n++;
        m_rst = reset;
        if (reset || flush) begin
            m_have = 0;
        end else if (acc) begin
            m_have     = 1;
            m_vis_edge = edge_n + LAT - 1;
            m_addr     = req_addr;
            m_err      = (req_addr % 4 != 0) || (req_addr >= 32'(4 << ADDR_W));
            if (m_err) m_instr = NOP;
            else       m_instr = m_mem[req_addr / 4];
        end else if (vis && rsp_ready) begin
            m_have = 0;
        end
        if (prog_we) m_mem[prog_addr] = prog_data;
        #1;
        chk("model rsp_valid", rsp_valid, m_vis());
        if (m_rst) begin
            chk("model reset instr", rsp_instr, NOP);
            chk("model reset addr", rsp_addr, 0);
            chk("model reset err", rsp_err, 0);
        end else if (m_vis()) begin
            chk("model rsp_instr", rsp_instr, m_instr);
            chk("model rsp_addr", rsp_addr, m_addr);
            chk("model rsp_err", rsp_err, m_err);
        end
    end

    always @(negedge clk) begin
        chk("model req_ready", req_ready, m_ready());
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_valid(input string name);
        int k;
        k = 0;
        #1;
        while (!rsp_valid && k < 40) begin
            step();
            k++;
        end
        chk({name, " valid"}, rsp_valid, 1);
    endtask

    task automatic fetch(input logic [31:0] addr, input logic [31:0] exp_instr,
                         input logic exp_err, input string name);
        int k;
        req_valid = 1; req_addr = addr; rsp_ready = 0;
        k = 0;
        #1;
        while (!req_ready && k < 40) begin
            step();
            #1;
            k++;
        end
        chk({name, " ready"}, req_ready, 1);
        step();
        req_valid = 0;
        wait_valid(name);
        chk({name, " instr"}, rsp_instr, exp_instr);
        chk({name, " addr"}, rsp_addr, addr);
        chk({name, " err"}, rsp_err, exp_err);
        rsp_ready = 1;
        step();
        rsp_ready = 0;
    endtask

    initial begin
        int r;
        reset = 1; req_valid = 0; req_addr = 0; rsp_ready = 0; flush = 0;
        prog_we = 0; prog_addr = 0; prog_data = 0;

        // Preload every word while reset is held (program load works in reset)
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            prog_we = 1; prog_addr = ADDR_W'(i); prog_data = $urandom;
            step();
        end
        prog_we = 0;
        chk("reset valid", rsp_valid, 0);
        chk("reset instr", rsp_instr, NOP);
        chk("reset addr", rsp_addr, 0);
        reset = 0;
        #1 chk("ready after reset", req_ready, 1);

        // Basic fetch
        prog_we = 1; prog_addr = 3; prog_data = 32'hC000_0008; step();
        prog_addr = 4; prog_data = 32'h1234_5678; step();
        prog_we = 0;
        req_valid = 1; req_addr = 32'h0C; rsp_ready = 0;
        #1 chk("basic ready", req_ready, 1);
        step();
        req_valid = 0;
        chk("basic lat1", rsp_valid, 0);
        step();
        chk("basic lat2", rsp_valid, 1);
        chk("basic instr", rsp_instr, 32'hC000_0008);
        chk("basic addr", rsp_addr, 32'h0C);
        chk("basic err", rsp_err, 0);

        // Backpressure, then back-to-back accept on the handshake cycle
        repeat (5) begin
            step();
            chk("bp valid", rsp_valid, 1);
            chk("bp instr", rsp_instr, 32'hC000_0008);
            chk("bp addr", rsp_addr, 32'h0C);
        end
        rsp_ready = 1; req_valid = 1; req_addr = 32'h10;
        #1 chk("b2b ready", req_ready, 1);
        step();
        req_valid = 0;
        chk("b2b gap", rsp_valid, 0);
        step();
        chk("b2b valid", rsp_valid, 1);
        chk("b2b instr", rsp_instr, 32'h1234_5678);
        chk("b2b addr", rsp_addr, 32'h10);
        step();
        rsp_ready = 0;

        // Errors
        fetch(32'h0000_0006, NOP, 1, "err misaligned");
        fetch(32'h0001_0000, NOP, 1, "err range");

        // Flush in BUSY
        req_valid = 1; req_addr = 32'h0C; rsp_ready = 0;
        step();
        req_valid = 0; flush = 1;
        step();
        flush = 0;
        chk("flush busy", rsp_valid, 0);
        step();
        chk("flush busy later", rsp_valid, 0);

        // Flush in HOLD with a same-cycle request
        req_valid = 1; req_addr = 32'h10;
        step();
        req_valid = 0;
        step();
        chk("hold reached", rsp_valid, 1);
        flush = 1; req_valid = 1; req_addr = 32'h0C;
        #1 chk("flush ready", req_ready, 0);
        step();
        flush = 0;
        chk("flush hold", rsp_valid, 0);
        fetch(32'h0C, 32'hC000_0008, 0, "post flush");

        // Write/read race on word 7
        prog_we = 1; prog_addr = 7; prog_data = WORD_A;
        step();
        prog_data = WORD_B; req_valid = 1; req_addr = 32'h1C; rsp_ready = 0;
        #1 chk("race ready", req_ready, 1);
        step();
        prog_we = 0; req_valid = 0;
        wait_valid("race");
        chk("race old word", rsp_instr, WORD_A);
        rsp_ready = 1;
        step();
        rsp_ready = 0;
        fetch(32'h1C, WORD_B, 0, "race new word");

        // Reset while holding a response
        req_valid = 1; req_addr = 32'h10;
        step();
        req_valid = 0;
        step();
        chk("rst hold", rsp_valid, 1);
        reset = 1;
        #1 chk("rst ready low", req_ready, 0);
        step();
        chk("rst valid", rsp_valid, 0);
        chk("rst instr", rsp_instr, NOP);
        chk("rst addr", rsp_addr, 0);
        chk("rst err", rsp_err, 0);
        reset = 0;
        #1 chk("rst ready high", req_ready, 1);
        fetch(32'h1C, WORD_B, 0, "rst store kept");

        // Random traffic against the model
        repeat (3000) begin
            reset     = ($urandom_range(0, 199) == 0);
            flush     = ($urandom_range(0, 19) == 0);
            req_valid = $urandom_range(0, 1) != 0;
            rsp_ready = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 9);
            if (r == 0)      req_addr = 32'($urandom_range(0, 255));
            else if (r == 1) req_addr = $urandom;
            else             req_addr = 32'($urandom_range(0, 63) * 4);
            prog_we   = ($urandom_range(0, 7) == 0);
            prog_addr = ADDR_W'($urandom_range(0, 63));
            prog_data = $urandom;
            step();
        end
        reset = 0; flush = 0; req_valid = 0; rsp_ready = 1; prog_we = 0;
        repeat (5) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
